// File: rtl/motor_mux_ctrl.sv
// Remap controller for the per-slot motor_mux select/invert settings.
// Stalls stepping, waits for a quiet window, switches, then holds off for DIR setup.
module motor_mux_ctrl #(
  parameter int N_DRV        = 4,
  parameter int QUIET_CYCLES = 4,
  parameter int DIR_SETUP    = 8,
  parameter int TIMEOUT      = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_x,
  input  logic                 step_y,
  input  logic                 step_z,
  input  logic                 estop,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2*N_DRV-1:0]   cfg_sel,
  input  logic [N_DRV-1:0]     cfg_inv,
  output logic [2*N_DRV-1:0]   mux_select,
  output logic [N_DRV-1:0]     invert_dir,
  output logic                 step_hold,
  output logic                 busy,
  output logic                 cfg_done,
  output logic                 cfg_err
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam logic [QW-1:0] Q_END = QW'(QUIET_CYCLES);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_END = SW'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_APPLY, S_SETTLE, S_DONE, S_ABORT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*N_DRV-1:0]   r_pend_sel;
  logic [N_DRV-1:0]     r_pend_inv;
  logic [2*N_DRV-1:0]   r_sel;
  logic [N_DRV-1:0]     r_inv;
  logic [QW-1:0]        r_qcnt;
  logic [TW-1:0]        r_tcnt;
  logic [SW-1:0]        r_scnt;
  logic                 r_step_hold;
  logic                 r_cfg_done;
  logic                 r_cfg_err;

  logic                 w_step_any;
  logic                 w_xfer;
  logic                 w_same;
  logic [QW-1:0]        w_qcnt_nxt;
  logic                 w_quiet;
  logic                 w_tout;
  logic                 w_settled;

  assign w_step_any = step_x | step_y | step_z;
  assign cfg_ready  = (r_state == S_IDLE) && !estop;
  assign w_xfer     = cfg_valid && cfg_ready;
  assign w_same     = (cfg_sel == r_sel) && (cfg_inv == r_inv);
  assign w_qcnt_nxt = w_step_any ? '0 : r_qcnt + QW'(1);
  // Quiet window wins over timeout when both land on the same cycle.
  assign w_quiet    = (w_qcnt_nxt == Q_END);
  assign w_tout     = (r_tcnt == T_END);
  assign w_settled  = (r_scnt == S_END);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer) w_state_nxt = w_same ? S_DONE : S_HOLD;
      S_HOLD: begin
        if (w_quiet)     w_state_nxt = S_APPLY;
        else if (w_tout) w_state_nxt = S_ABORT;
      end
      S_APPLY:  w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settled) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      S_ABORT:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (estop) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend_sel  <= '0;
      r_pend_inv  <= '0;
      r_sel       <= '0;
      r_inv       <= '0;
      r_qcnt      <= '0;
      r_tcnt      <= '0;
      r_scnt      <= '0;
      r_step_hold <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step_hold <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_APPLY) ||
                     (w_state_nxt == S_SETTLE);
      r_cfg_done  <= (w_state_nxt == S_DONE);
      r_cfg_err   <= estop ? ((r_state != S_IDLE) && (r_state != S_DONE))
                           : (w_state_nxt == S_ABORT);
      if (w_xfer) begin
        r_pend_sel <= cfg_sel;
        r_pend_inv <= cfg_inv;
      end
      case (r_state)
        S_IDLE: begin
          r_qcnt <= '0;
          r_tcnt <= '0;
        end
        S_HOLD: begin
          r_qcnt <= w_qcnt_nxt;
          r_tcnt <= r_tcnt + TW'(1);
        end
        S_APPLY: begin
          if (!estop) begin
            r_sel <= r_pend_sel;
            r_inv <= r_pend_inv;
          end
          r_scnt <= '0;
        end
        S_SETTLE: r_scnt <= r_scnt + SW'(1);
        default: ;
      endcase
      // E-stop parks every slot; invert settings are left alone.
      if (estop) r_sel <= '0;
    end
  end

  assign mux_select = r_sel;
  assign invert_dir = r_inv;
  assign step_hold  = r_step_hold;
  assign busy       = (r_state != S_IDLE);
  assign cfg_done   = r_cfg_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_motor_mux_ctrl.sv
// Directed bench for motor_mux_ctrl: remap, steps in HOLD, timeout, same-config, estop, async reset.
module tb_motor_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_x, step_y, step_z, estop, cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_sel;
  logic [3:0] cfg_inv;
  logic [7:0] mux_select;
  logic [3:0] invert_dir;
  logic       step_hold, busy, cfg_done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  motor_mux_ctrl #(
    .N_DRV(4), .QUIET_CYCLES(4), .DIR_SETUP(8), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .step_x(step_x), .step_y(step_y), .step_z(step_z),
    .estop(estop), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_inv(cfg_inv),
    .mux_select(mux_select), .invert_dir(invert_dir),
    .step_hold(step_hold), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [7:0] sel, input logic [3:0] inv);
    cfg_sel   = sel;
    cfg_inv   = inv;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int hc, dc, w, errs;
    rst_n = 1'b0; step_x = 0; step_y = 0; step_z = 0; estop = 0;
    cfg_valid = 0; cfg_sel = '0; cfg_inv = '0;
    tick(2);
    chk("rst_sel",   32'(mux_select), 32'h0);
    chk("rst_inv",   32'(invert_dir), 32'h0);
    chk("rst_hold",  32'(step_hold),  32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    chk("rst_done",  32'(cfg_done),   32'h0);
    chk("rst_err",   32'(cfg_err),    32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(cfg_ready),  32'h1);

    // Clean remap: 4 HOLD + 1 APPLY + 8 SETTLE, then one DONE cycle
    request(8'h39, 4'h5);
    chk("rm_busy",  32'(busy),      32'h1);
    chk("rm_ready", 32'(cfg_ready), 32'h0);
    hc = 0; dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (step_hold) hc++;
      if (cfg_done) dc++;
      if (i == 4)  chk("rm_apply_old_sel", 32'(mux_select), 32'h0);
      if (i == 5)  chk("rm_settle_new_sel", 32'(mux_select), 32'h39);
      if (i == 13) chk("rm_done_pulse", 32'(cfg_done), 32'h1);
      tick();
    end
    chk("rm_hold_cycles", 32'(hc), 32'd13);
    chk("rm_done_count",  32'(dc), 32'd1);
    chk("rm_sel", 32'(mux_select), 32'h39);
    chk("rm_inv", 32'(invert_dir), 32'h5);
    chk("rm_idle_ready", 32'(cfg_ready), 32'h1);

    // Step pulses every 3 cycles keep the FSM in HOLD
    request(8'h1B, 4'hA);
    for (int i = 0; i < 20; i++) begin
      chk("st_hold_in_loop", 32'(step_hold), 32'h1);
      step_x = (i % 3 == 0);
      tick();
    end
    step_x = 1'b0;
    chk("st_sel_unchanged", 32'(mux_select), 32'h39);
    w = 0;
    while (mux_select != 8'h1B && w < 50) begin
      tick();
      w++;
    end
    chk("st_quiet_wait", 32'(w), 32'd4);
    chk("st_hold_at_change", 32'(step_hold), 32'h1);
    tick(8);
    chk("st_done", 32'(cfg_done), 32'h1);
    chk("st_inv", 32'(invert_dir), 32'hA);
    tick();

    // Same config re-request goes straight to DONE
    request(8'h1B, 4'hA);
    chk("same_done", 32'(cfg_done),  32'h1);
    chk("same_hold", 32'(step_hold), 32'h0);
    chk("same_busy", 32'(busy),      32'h1);
    tick();
    chk("same_done_off", 32'(cfg_done), 32'h0);
    chk("same_idle",     32'(busy),     32'h0);

    // Timeout: toggling step_y prevents a quiet window
    request(8'hE4, 4'hF);
    w = 0;
    while (!cfg_err && w < 200) begin
      step_y = ~step_y;
      tick();
      w++;
    end
    step_y = 1'b0;
    chk("to_cycles", 32'(w), 32'd64);
    chk("to_err",  32'(cfg_err),    32'h1);
    chk("to_sel",  32'(mux_select), 32'h1B);
    chk("to_inv",  32'(invert_dir), 32'hA);
    chk("to_hold", 32'(step_hold),  32'h0);
    chk("to_done", 32'(cfg_done),   32'h0);
    tick();
    chk("to_err_off", 32'(cfg_err), 32'h0);
    chk("to_idle",    32'(busy),    32'h0);

    // E-stop during HOLD with cfg_valid held high
    request(8'h27, 4'h0);
    tick();
    chk("es_in_hold", 32'(step_hold), 32'h1);
    estop = 1'b1;
    cfg_valid = 1'b1;
    #1;
    chk("es_ready_low", 32'(cfg_ready), 32'h0);
    tick();
    chk("es_sel",  32'(mux_select), 32'h0);
    chk("es_inv",  32'(invert_dir), 32'hA);
    chk("es_err",  32'(cfg_err),    32'h1);
    chk("es_hold", 32'(step_hold),  32'h0);
    chk("es_busy", 32'(busy),       32'h0);
    tick();
    chk("es_err_off", 32'(cfg_err), 32'h0);
    tick(3);
    chk("es_ignored_busy",  32'(busy),      32'h0);
    chk("es_ignored_ready", 32'(cfg_ready), 32'h0);
    estop = 1'b0;
    cfg_valid = 1'b0;
    #1;
    chk("es_ready_back", 32'(cfg_ready), 32'h1);
    tick();
    chk("es_no_restore", 32'(mux_select), 32'h0);

    // Async reset in the middle of SETTLE
    request(8'h93, 4'h3);
    tick(6);
    chk("ar_settle_hold", 32'(step_hold),  32'h1);
    chk("ar_settle_sel",  32'(mux_select), 32'h93);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel",  32'(mux_select), 32'h0);
    chk("ar_inv",  32'(invert_dir), 32'h0);
    chk("ar_hold", 32'(step_hold),  32'h0);
    chk("ar_busy", 32'(busy),       32'h0);
    chk("ar_done", 32'(cfg_done),   32'h0);
    chk("ar_err",  32'(cfg_err),    32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_ready", 32'(cfg_ready), 32'h1);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (cfg_done || cfg_err || busy) errs++;
      tick();
    end
    chk("ar_quiet_after", 32'(errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
